multdiv_ctrl: RTL and testbench

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

---
 rtl/multdiv_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// multdiv_ctrl -- sequencing controller for an iterative multiply/divide
// datapath.
//
// An accepted start request moves IDLE -> LOAD (one operand-load strobe),
// then RUN for ITER cycles (one shift/add or shift/subtract per cycle), then
// DONE (one-cycle result-valid pulse with the exception flag).
// A divide with a zero divisor skips RUN. A multiply whose final iteration
// reports overflow finishes with the exception flag set.
//
// Configuration macro: MULTDIV_DIV_EN
//   defined   : divide requests are sequenced like multiplies.
//   undefined : a divide-only request goes straight to DONE with the
//               exception flag set; sel_div is tied to 0.
//
// Parameters
//   ITER            iteration cycles per operation (1..63)
// Ports
//   clk             clock, rising edge
//   clr             asynchronous active-high reset
//   ctrl_MULT       start-multiply request (wins over ctrl_DIV)
//   ctrl_DIV        start-divide request
//   divisor_zero    datapath flag: divisor operand is zero
//   mult_overflow   datapath flag: product exceeds 32 bits
//   load            operand-load strobe
//   step_en         datapath iterate enable
//   sel_div         datapath mode: 0 multiply, 1 divide
//   iter_count      current iteration index
//   busy            high whenever the controller is not idle
//   data_resultRDY  one-cycle result-valid pulse
//   data_exception  exception flag, qualified by data_resultRDY
// ---------------------------------------------------------------------------
module multdiv_ctrl #(
    parameter int ITER = 32
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ctrl_MULT,
    input  logic       ctrl_DIV,
    input  logic       divisor_zero,
    input  logic       mult_overflow,
    output logic       load,
    output logic       step_en,
    output logic       sel_div,
    output logic [5:0] iter_count,
    output logic       busy,
    output logic       data_resultRDY,
    output logic       data_exception
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [5:0] LAST_ITER = 6'(ITER - 1);

    state_t     state_q, state_d;
    logic [5:0] iter_q;
    logic       sel_q;
    logic       exc_q;
    logic       accept;     // a start request is being taken this cycle
    logic       div_only;   // divide requested without a competing multiply
    logic       last_step;

    assign accept    = (state_q == IDLE || state_q == DONE) && (ctrl_MULT || ctrl_DIV);
    assign div_only  = ctrl_DIV && !ctrl_MULT;
    assign last_step = (state_q == RUN) && (iter_q == LAST_ITER);

    // Next-state and strobe decode. The start branch is shared by IDLE and
    // DONE so back-to-back operations need no idle cycle.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        state_d        = state_q;
        load           = 1'b0;
        step_en        = 1'b0;
        data_resultRDY = 1'b0;
        case (state_q)
            LOAD: begin
                load    = 1'b1;
                state_d = (sel_q && divisor_zero) ? DONE : RUN;
            end
            RUN: begin
                step_en = 1'b1;
                if (last_step) state_d = DONE;
            end
            DONE: begin
                data_resultRDY = 1'b1;
                state_d        = IDLE;
            end
            default: ;
        endcase
        if (accept) begin
`ifdef MULTDIV_DIV_EN
            state_d = LOAD;
`else
            // Without divide support a divide-only request is rejected at
            // once: straight to DONE, flagged as an exception.
            state_d = div_only ? DONE : LOAD;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Iteration counter: cleared while loading, stepped through RUN, and
    // held at ITER-1 on the final step so it never wraps.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            iter_q <= '0;
        end else if (state_q == LOAD) begin
            iter_q <= '0;
        end else if (state_q == RUN && !last_step) begin
            iter_q <= iter_q + 6'd1;
        end
    end

    // Exception latch: cleared on every accepted start, then set by a zero
    // divisor seen in LOAD or by overflow seen on the final multiply step.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            exc_q <= 1'b0;
        end else if (accept) begin
`ifdef MULTDIV_DIV_EN
            exc_q <= 1'b0;
`else
            exc_q <= div_only;
`endif
        end else if (state_q == LOAD && sel_q && divisor_zero) begin
            exc_q <= 1'b1;
        end else if (last_step && !sel_q && mult_overflow) begin
            exc_q <= 1'b1;
        end
    end

`ifdef MULTDIV_DIV_EN
    // Mode is latched only when a start is accepted; requests arriving in
    // LOAD or RUN leave it untouched.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)         sel_q <= 1'b0;
        else if (accept) sel_q <= div_only;
    end
`else
    assign sel_q = 1'b0;
`endif

    assign sel_div        = sel_q;
    assign iter_count     = iter_q;
    assign busy           = (state_q != IDLE);
    assign data_exception = data_resultRDY && exc_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multdiv_ctrl -- self-checking bench for multdiv_ctrl (ITER = 32).
//
// Cycle 0 is the cycle in which a start request is driven. Inputs change and
// outputs are sampled on the falling clock edge. A table of operations is
// run through one task that records the load, step and result timing; the
// expected record is pushed to a scoreboard queue at start and popped when
// the result pulse appears. Hand-written sequences cover back-to-back
// starts, starts ignored during RUN, and a reset abort mid-operation.
// Works with or without MULTDIV_DIV_EN defined.
// ---------------------------------------------------------------------------
module tb_multdiv_ctrl;

    localparam int N      = 32;       // ITER
    localparam int LAT    = N + 2;    // start to result pulse
    localparam int BUDGET = 80;       // cycle bound per operation

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       ctrl_MULT = 1'b0;
    logic       ctrl_DIV = 1'b0;
    logic       divisor_zero = 1'b0;
    logic       mult_overflow = 1'b0;
    logic       load, step_en, sel_div, busy, data_resultRDY, data_exception;
    logic [5:0] iter_count;

    int n_tests = 0;
    int n_fail  = 0;

    multdiv_ctrl #(.ITER(N)) dut (
        .clk            (clk),
        .clr            (clr),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .divisor_zero   (divisor_zero),
        .mult_overflow  (mult_overflow),
        .load           (load),
        .step_en        (step_en),
        .sel_div        (sel_div),
        .iter_count     (iter_count),
        .busy           (busy),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception)
    );

    always #5 clk = ~clk;

    // ovf_mode: 0 never, 1 only in the final RUN cycle, 2 every RUN cycle
    // except the final one. inj: cycle at which both start requests are
    // pulsed again (0 = none). exp_load: expected load cycle, 0 = no load.
    typedef struct {
        string name;
        logic  mult;
        logic  div;
        logic  dz;
        int    ovf_mode;
        int    inj;
        int    exp_load;
        int    exp_steps;
        int    exp_rdy;
        logic  exp_exc;
        logic  exp_sel;
    } vec_t;

    vec_t sb_q[$];
    vec_t tab[8];

    function automatic vec_t mkv(string name, logic mult, logic div, logic dz,
                                 int ovf_mode, int inj, int exp_load, int exp_steps,
                                 int exp_rdy, logic exp_exc, logic exp_sel);
        vec_t v;
        v.name = name; v.mult = mult; v.div = div; v.dz = dz;
        v.ovf_mode = ovf_mode; v.inj = inj; v.exp_load = exp_load;
        v.exp_steps = exp_steps; v.exp_rdy = exp_rdy; v.exp_exc = exp_exc;
        v.exp_sel = exp_sel;
        return v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Entered on a falling edge; that cycle becomes cycle 0. Returns on the
    // falling edge of the result cycle with the start inputs released, so a
    // following call starts a new operation in the DONE cycle.
    task automatic run_op(input vec_t v);
        vec_t e;
        int   load_cyc = 0, load_cnt = 0, steps = 0, rdy_cyc = 0;
        int   iter_err = 0, mutex_err = 0, exc = 0, sel = 0;
        bit   got = 0;
        ctrl_MULT    = v.mult;
        ctrl_DIV     = v.div;
        divisor_zero = v.dz;
        sb_q.push_back(v);
        for (int c = 1; c <= BUDGET && !got; c++) begin
            @(negedge clk);
            if (int'(load) + int'(step_en) + int'(data_resultRDY) > 1) mutex_err++;
            if (load) begin
                load_cnt++;
                if (load_cyc == 0) load_cyc = c;
            end
            if (step_en) begin
                if (int'(iter_count) != steps) iter_err++;
                steps++;
            end
            if (data_resultRDY) begin
                got = 1;
                rdy_cyc = c;
                exc = int'(data_exception);
                sel = int'(sel_div);
            end
            ctrl_MULT     = !got && (c == v.inj);
            ctrl_DIV      = !got && (c == v.inj);
            mult_overflow = !got && ((v.ovf_mode == 1 && c == N + 1) ||
                                     (v.ovf_mode == 2 && c >= 2 && c <= N));
        end
        divisor_zero = 1'b0;
        if (!got) check({v.name, " result timeout"}, 0, 1);
        e = sb_q.pop_front();
        check({e.name, " rdy_cycle"}, rdy_cyc, e.exp_rdy);
        check({e.name, " exception"}, exc, int'(e.exp_exc));
        check({e.name, " sel_div"}, sel, int'(e.exp_sel));
        check({e.name, " step_count"}, steps, e.exp_steps);
        check({e.name, " load_cycle"}, load_cyc, e.exp_load);
        check({e.name, " load_count"}, load_cnt, (e.exp_load != 0) ? 1 : 0);
        check({e.name, " iter_seq_err"}, iter_err, 0);
        check({e.name, " mutex_err"}, mutex_err, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_outputs",
                  int'({busy, load, step_en, data_resultRDY, data_exception}), 0);
        end
    endtask

    vec_t div_v;
    vec_t inj_v;

    initial begin
        // Table of single operations.
        tab[0] = mkv("mult",          1, 0, 0, 0, 0, 1, N, LAT, 0, 0);
        tab[1] = mkv("mult_ovf_last", 1, 0, 0, 1, 0, 1, N, LAT, 1, 0);
        tab[2] = mkv("mult_ovf_early",1, 0, 0, 2, 0, 1, N, LAT, 0, 0);
        tab[3] = mkv("both_ovf",      1, 1, 0, 1, 0, 1, N, LAT, 1, 0);
        tab[4] = mkv("both_dz",       1, 1, 1, 0, 0, 1, N, LAT, 0, 0);
`ifdef MULTDIV_DIV_EN
        tab[5] = mkv("div",           0, 1, 0, 0, 0, 1, N, LAT, 0, 1);
        tab[6] = mkv("div_zero",      0, 1, 1, 0, 0, 1, 0, 2,   1, 1);
        tab[7] = mkv("div_ovf",       0, 1, 0, 1, 0, 1, N, LAT, 0, 1);
        div_v  = mkv("div_after",     0, 1, 0, 0, 0, 1, N, LAT, 0, 1);
`else
        tab[5] = mkv("div_rej",       0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        tab[6] = mkv("div_rej_dz",    0, 1, 1, 0, 0, 0, 0, 1, 1, 0);
        tab[7] = mkv("div_rej_ovf",   0, 1, 0, 1, 0, 0, 0, 1, 1, 0);
        div_v  = mkv("div_after",     0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
`endif
        inj_v = mkv("mult_inj", 1, 0, 0, 0, 10, 1, N, LAT, 0, 0);

        // Reset state, observed while clr is still asserted.
        #2;
        check("reset_outputs",
              int'({load, step_en, sel_div, busy, data_resultRDY, data_exception}), 0);
        check("reset_iter_count", int'(iter_count), 0);

        // Start in the very first cycle after reset release.
        @(negedge clk);
        clr = 1'b0;
        foreach (tab[i]) begin
            run_op(tab[i]);
            idle(2);
        end

        // Starts during RUN are ignored; a divide issued in the DONE cycle
        // is accepted immediately.
        run_op(inj_v);
        run_op(div_v);
        idle(2);

        // Reset at RUN iteration 10 aborts without a result pulse.
        ctrl_MULT = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            ctrl_MULT = 1'b0;
        end
        check("abort_pre_iter", int'(iter_count), 10);
        check("abort_pre_step", int'(step_en), 1);
        #1 clr = 1'b1;
        #1;
        check("abort_outputs",
              int'({load, step_en, sel_div, busy, data_resultRDY, data_exception}), 0);
        check("abort_iter_count", int'(iter_count), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_hold", int'({busy, data_resultRDY}), 0);
        end
        clr = 1'b0;
        run_op(div_v);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
